// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment sniffer: active-low segment patterns (bit0=a .. bit6=g),
// the blank BCD code, and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low segment pattern to BCD decoder.
// is_valid covers the ten digits and blank; is_blank flags the all-off pattern (bcd = 4'hF).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] bcd,
  output logic       is_blank,
  output logic       is_valid
);

  always_comb begin
    bcd      = BCD_BLANK;
    is_blank = 1'b0;
    is_valid = 1'b1;
    case (seg_n)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: is_blank = 1'b1;
      default:   is_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_to_bcd_capture.sv
// Sniffs a multiplexed 7-seg display into 4 BCD digits; a held input lands in DIGITS 2+STABLE_CYCLES edges later.
// Optional decimal-point capture under SEG7_CAP_DP_EN (adds DP_N input and DP output).
module seg7_to_bcd_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        CLOCK_50,
  input  logic        RST,
  input  logic [6:0]  SEG_N,
  input  logic [3:0]  AN_N,
`ifdef SEG7_CAP_DP_EN
  input  logic        DP_N,
  output logic [3:0]  DP,
`endif
  input  logic        ERR_CLR,
  output logic [15:0] DIGITS,
  output logic [3:0]  BLANK,
  output logic        FRAME_VALID,
  output logic        SEG_ERR
);

`ifdef SEG7_CAP_DP_EN
  localparam int SW = 12;
`else
  localparam int SW = 11;
`endif
  localparam logic [7:0] STABLE = STABLE_CYCLES[7:0];

  logic [SW-1:0] sample_in;
  logic [SW-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [7:0]    cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [15:0]   digits_q, digits_d;
  logic [3:0]    blank_q, blank_d, mask_q, mask_d;
  logic          fv_q, fv_d, err_q, err_d;
  logic [6:0]    seg_s;
  logic [3:0]    an_s, bcd;
  logic          is_blank, is_valid;
  logic          changed, settle_done, one_low, cap_ok, cap_bad;

`ifdef SEG7_CAP_DP_EN
  logic [3:0] dp_q, dp_d;
  assign sample_in = {DP_N, AN_N, SEG_N};
  assign DP        = dp_q;
`else
  assign sample_in = {AN_N, SEG_N};
`endif

  assign seg_s = sync2_q[6:0];
  assign an_s  = sync2_q[10:7];

  seg7_decode u_decode (
    .seg_n    (seg_s),
    .bcd      (bcd),
    .is_blank (is_blank),
    .is_valid (is_valid)
  );

  always_comb begin
    sync1_d     = sample_in;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    changed     = (sync2_q != prev_q);
    settle_done = 1'b0;
    state_d     = state_q;

    if (changed)              cnt_d = '0;
    else if (cnt_q == STABLE) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 8'd1;

    case (state_q)
      WAIT:    if (changed) state_d = SETTLE;
      SETTLE:  if (cnt_d == STABLE) begin
                 state_d     = HELD;
                 settle_done = 1'b1;
               end
      HELD:    if (changed) state_d = SETTLE;
      default: state_d = WAIT;
    endcase

    one_low = (an_s == 4'b1110) || (an_s == 4'b1101) ||
              (an_s == 4'b1011) || (an_s == 4'b0111);
    cap_ok  = settle_done && one_low && is_valid;
    cap_bad = settle_done && one_low && !is_valid;

    digits_d = digits_q;
    blank_d  = blank_q;
    fv_d     = (mask_q == 4'b1111);
    // A full mask is cleared here, but a capture landing this same edge still records its bit.
    mask_d   = fv_d ? 4'b0000 : mask_q;
`ifdef SEG7_CAP_DP_EN
    dp_d     = dp_q;
`endif
    for (int i = 0; i < 4; i++) begin
      if (cap_ok && !an_s[i]) begin
        digits_d[4*i +: 4] = bcd;
        blank_d[i]         = is_blank;
        mask_d[i]          = 1'b1;
`ifdef SEG7_CAP_DP_EN
        dp_d[i]            = ~sync2_q[11];
`endif
      end
    end

    err_d = err_q;
    if (ERR_CLR) err_d = 1'b0;
    if (cap_bad) err_d = 1'b1;
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '1;
      cnt_q    <= '0;
      state_q  <= WAIT;
      digits_q <= 16'hFFFF;
      blank_q  <= 4'b1111;
      mask_q   <= 4'b0000;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
`ifdef SEG7_CAP_DP_EN
      dp_q     <= 4'b0000;
`endif
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      mask_q   <= mask_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
`ifdef SEG7_CAP_DP_EN
      dp_q     <= dp_d;
`endif
    end
  end

  assign DIGITS      = digits_q;
  assign BLANK       = blank_q;
  assign FRAME_VALID = fv_q;
  assign SEG_ERR     = err_q;

endmodule

// File: doc/seg7_to_bcd_capture.md
SEG7_TO_BCD_CAPTURE -- requirements
Module: seg7_to_bcd_capture

Interface
- REQ-001: Parameter STABLE_CYCLES, default 4, is the number of consecutive identical synchronized samples required before a capture; the legal range SHALL be 2..255.
- REQ-002: Port CLOCK_50, input, width 1, SHALL be the single clock; all state is updated on the rising edge.
- REQ-003: Port RST, input, width 1, SHALL be the asynchronous, active-high reset.
- REQ-004: Port SEG_N, input, width 7, SHALL carry the active-low segments of the sniffed display, with bit0=a through bit6=g.
- REQ-005: Port AN_N, input, width 4, SHALL carry the active-low digit enables of the sniffed multiplexed display.
- REQ-006: Port ERR_CLR, input, width 1, SHALL clear SEG_ERR when high.
- REQ-007: Port DIGITS, output, width 16, SHALL carry {d3,d2,d1,d0} as 4-bit BCD, with 4'hF meaning blank.
- REQ-008: Port BLANK, output, width 4, SHALL have one bit per digit, high when that digit was last captured as blank.
- REQ-009: Port FRAME_VALID, output, width 1, SHALL be a one-cycle pulse when all four digits have been captured since the previous pulse.
- REQ-010: Port SEG_ERR, output, width 1, SHALL be a sticky flag indicating that an unrecognised segment pattern was captured.

Function
- REQ-011: SEG_N and AN_N SHALL pass through a 2-flop synchronizer before any other use.
- REQ-012: Stability counter:
  - The counter SHALL clear on any cycle where the synchronized {AN_N,SEG_N} differs from the previous cycle's sample.
  - The counter SHALL increment otherwise.
  - The counter SHALL saturate at STABLE_CYCLES.
- REQ-013: The FSM SHALL have states WAIT, SETTLE and HELD, with these transitions:
  - WAIT->SETTLE on any sample change.
  - SETTLE->HELD when the counter reaches STABLE_CYCLES; the capture occurs on that edge.
  - HELD->SETTLE on any change.
- REQ-014: A capture SHALL occur only if synchronized AN_N has exactly one bit low; otherwise the FSM SHALL enter HELD without capture and without error.
- REQ-015: A capture SHALL occur exactly once per stable period; a pattern held indefinitely SHALL NOT re-capture.
- REQ-016: The decode SHALL map the following SEG_N patterns to BCD:
  - 1000000 -> 0
  - 1111001 -> 1
  - 0100100 -> 2
  - 0110000 -> 3
  - 0011001 -> 4
  - 0010010 -> 5
  - 0000010 -> 6
  - 1111000 -> 7
  - 0000000 -> 8
  - 0010000 -> 9
  - 1111111 -> 4'hF with BLANK set
- REQ-017: On capture of a valid or blank pattern, the enabled digit's DIGITS nibble and BLANK bit SHALL be written, and its seen-mask bit SHALL be set.
- REQ-018: On capture of any other pattern, DIGITS, BLANK and the seen mask SHALL be unchanged, and SEG_ERR SHALL be set.
- REQ-019: When the seen mask equals 4'b1111, FRAME_VALID SHALL pulse on the following cycle and the mask SHALL clear on that same cycle.
- REQ-020: If a capture coincides with the mask clear, the new capture's bit SHALL survive into the cleared mask.
- REQ-021: Latency: an input held constant from edge k SHALL update DIGITS at edge k+2+STABLE_CYCLES, and FRAME_VALID SHALL follow one cycle after the fourth digit's update.
- REQ-022: If ERR_CLR is high in the same cycle as a new error, the set SHALL win.

Reset
- REQ-023: While RST is high, the following SHALL hold:
  - DIGITS=16'hFFFF.
  - BLANK=4'b1111.
  - FRAME_VALID=0.
  - SEG_ERR=0.
  - Seen mask=0.
  - Counter=0.
  - FSM=WAIT.
  - Synchronizers=all ones (idle display).
- REQ-024: If RST asserts mid-settle, the partial capture SHALL be discarded; after release, capture SHALL restart from WAIT.

Configuration
- REQ-025: With macro SEG7_CAP_DP_EN defined:
  - Input DP_N (width 1, active-low decimal point) SHALL be synchronized with SEG_N.
  - DP_N SHALL be included in the stability compare.
  - DP_N SHALL be captured into output DP (width 4, one bit per digit, active-high, reset 0).
- REQ-026: Without SEG7_CAP_DP_EN, the ports DP_N and DP SHALL NOT exist, and behaviour SHALL be otherwise identical.

Structure
- REQ-027: Package seg7_pkg SHALL hold:
  - The ten digit patterns and the blank pattern as 7-bit constants.
  - Constant BCD_BLANK=4'hF.
  - The FSM state enum (WAIT, SETTLE, HELD).
- REQ-028: Combinational sub-module seg7_decode SHALL map a 7-bit pattern to {bcd[3:0], is_blank, is_valid}, and SHALL be instantiated once.

Verification
- REQ-029: Scenario "single digit": AN_N=1110, SEG_N=0100100, held 10 cycles, STABLE_CYCLES=4 -> DIGITS[3:0]=2 at cycle 6, no FRAME_VALID.
- REQ-030: Scenario "full frame": scan digits 0..3 with patterns 1,9,blank,7, 8 cycles each -> DIGITS=16'h7F91, BLANK=4'b0100, exactly one FRAME_VALID pulse.
- REQ-031: Scenario "glitch": a pattern changed every 3 cycles with STABLE_CYCLES=4 -> no capture, DIGITS stays 16'hFFFF.
- REQ-032: Scenario "bad pattern": SEG_N=0101010 held on digit 1 -> SEG_ERR=1, DIGITS unchanged, mask bit 1 clear; then ERR_CLR pulse -> SEG_ERR=0.
- REQ-033: Scenario "invalid enable": AN_N=1100 held -> no capture, SEG_ERR=0.
- REQ-034: Scenario "reset mid-settle": RST pulsed at cycle 3 of a 4-cycle settle -> all outputs at reset values, and the same pattern held afterwards captures 6 cycles after RST release.
